iomem_audio_regs: RTL and testbench



---
 rtl/iomem_audio_regs.sv | 150 +++++++++++++++
 tb/tb_iomem_audio_regs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_audio_regs.sv
// PicoSoC iomem slave for the audio path: per-channel phase increments, enables, GPIO, tick counter and IRQ.
// Define IOMEM_AUDIO_REGS_SHADOW_EN to commit frequency writes to ch_freq only on sample_tick.
module iomem_audio_regs #(
  parameter logic [7:0] BASE_ADDR  = 8'h04,
  parameter int         NUM_CH     = 4,
  parameter int         PHASE_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iomem_valid,
  output logic                         iomem_ready,
  input  logic [3:0]                   iomem_wstrb,
  input  logic [31:0]                  iomem_addr,
  input  logic [31:0]                  iomem_wdata,
  output logic [31:0]                  iomem_rdata,
  input  logic                         sample_tick,
  output logic [NUM_CH*PHASE_SIZE-1:0] ch_freq,
  output logic [NUM_CH-1:0]            ch_enable,
  output logic [31:0]                  gpio,
  output logic                         irq
);

  localparam logic [5:0] IDX_CTRL = 6'(NUM_CH);
  localparam logic [5:0] IDX_GPIO = 6'(NUM_CH + 1);
  localparam logic [5:0] IDX_TICK = 6'(NUM_CH + 2);

  logic [PHASE_SIZE-1:0] r_freq [NUM_CH];
  logic [NUM_CH-1:0]     r_enable;
  logic                  r_irqEn;
  logic [31:0]           r_gpio;
  logic [31:0]           r_tickCnt;
  logic                  r_pending;

  logic                  w_sel;
  logic                  w_accept;
  logic                  w_write;
  logic                  w_tickAccess;
  logic                  w_tickClear;
  logic [5:0]            w_idx;
  logic [31:0]           w_rdMux;
  logic [31:0]           w_ctrlRd;
  logic [31:0]           w_ctrlNew;
  logic                  w_unused;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = newVal[b*8 +: 8];
    return res;
  endfunction

  assign w_sel        = (iomem_addr[31:24] == BASE_ADDR);
  assign w_accept     = iomem_valid & w_sel & ~iomem_ready;
  assign w_write      = w_accept & (|iomem_wstrb);
  assign w_idx        = iomem_addr[7:2];
  assign w_tickAccess = w_accept && (w_idx == IDX_TICK);
  assign w_tickClear  = w_tickAccess && (|iomem_wstrb);
  assign w_ctrlRd     = 32'(r_enable) | (32'(r_irqEn) << 16);
  assign w_ctrlNew    = mergeBytes(w_ctrlRd, iomem_wdata, iomem_wstrb);
  assign w_unused     = &{1'b0, iomem_addr[23:8], iomem_addr[1:0]};

  always_comb begin
    w_rdMux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_idx == 6'(i)) w_rdMux = 32'(r_freq[i]);
    if (w_idx == IDX_CTRL) w_rdMux = w_ctrlRd;
    if (w_idx == IDX_GPIO) w_rdMux = r_gpio;
    if (w_idx == IDX_TICK) w_rdMux = r_tickCnt;
  end

  // Read data is captured from the pre-write register state on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= w_accept;
      if (w_accept) iomem_rdata <= w_rdMux;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_freq[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_write && (w_idx == 6'(i)))
          r_freq[i] <= PHASE_SIZE'(mergeBytes(32'(r_freq[i]), iomem_wdata, iomem_wstrb));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= '0;
      r_irqEn  <= 1'b0;
      r_gpio   <= '0;
    end else if (w_write) begin
      if (w_idx == IDX_CTRL) begin
        r_enable <= w_ctrlNew[NUM_CH-1:0];
        r_irqEn  <= w_ctrlNew[16];
      end
      if (w_idx == IDX_GPIO) r_gpio <= mergeBytes(r_gpio, iomem_wdata, iomem_wstrb);
    end
  end

  // A tick coinciding with a clear always wins: count restarts at 1 and PENDING stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tickCnt <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_tickClear)
        r_tickCnt <= 32'(sample_tick);
      else if (sample_tick)
        r_tickCnt <= r_tickCnt + 32'd1;
      if (sample_tick && r_irqEn)
        r_pending <= 1'b1;
      else if (w_tickAccess)
        r_pending <= 1'b0;
    end
  end

`ifdef IOMEM_AUDIO_REGS_SHADOW_EN
  logic [PHASE_SIZE-1:0] r_chFreq [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_chFreq[i] <= '0;
    end else if (sample_tick) begin
      for (int i = 0; i < NUM_CH; i++) r_chFreq[i] <= r_freq[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chFreq
    assign ch_freq[g*PHASE_SIZE +: PHASE_SIZE] = r_chFreq[g];
  end
`else
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chFreq
    assign ch_freq[g*PHASE_SIZE +: PHASE_SIZE] = r_freq[g];
  end
`endif

  assign ch_enable = r_enable;
  assign gpio      = r_gpio;
  assign irq       = r_pending & r_irqEn;

endmodule

// File: tb/tb_iomem_audio_regs.sv
// Self-checking bench for iomem_audio_regs: directed scenarios plus randomized bus/tick traffic
// compared every cycle against a transaction-level model of the register bank.
module tb_iomem_audio_regs;

  localparam logic [7:0] BASE = 8'h04;
  localparam int NCH = 4;
  localparam int PS  = 24;
  localparam logic [31:0] PSMASK = 32'h00FF_FFFF;

  logic                clk = 1'b0;
  logic                reset;
  logic                iomem_valid;
  logic                iomem_ready;
  logic [3:0]          iomem_wstrb;
  logic [31:0]         iomem_addr;
  logic [31:0]         iomem_wdata;
  logic [31:0]         iomem_rdata;
  logic                sample_tick;
  logic [NCH*PS-1:0]   ch_freq;
  logic [NCH-1:0]      ch_enable;
  logic [31:0]         gpio;
  logic                irq;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] mFreq [NCH];
  logic [31:0] mOut  [NCH];
  logic [NCH-1:0] mEn;
  logic        mIrqEn, mPend, mReady;
  logic [31:0] mGpio, mCnt, mRdata;

  logic        capReady1, capReady2, capIrq;
  logic [31:0] capRd, capGpio;
  logic [NCH*PS-1:0] capFreq;
  logic [NCH-1:0]    capEn;

  iomem_audio_regs #(.BASE_ADDR(BASE), .NUM_CH(NCH), .PHASE_SIZE(PS)) dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .sample_tick(sample_tick), .ch_freq(ch_freq),
    .ch_enable(ch_enable), .gpio(gpio), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] byteMask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8*b));
    return m;
  endfunction

  function automatic logic [31:0] modelRead(input int idx);
    if (idx < NCH) return mFreq[idx];
    if (idx == NCH) return ((mIrqEn ? 32'h1 : 32'h0) << 16) | 32'(mEn);
    if (idx == NCH + 1) return mGpio;
    if (idx == NCH + 2) return mCnt;
    return 32'h0;
  endfunction

  function automatic logic [NCH*PS-1:0] modelChFreq();
    logic [NCH*PS-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef IOMEM_AUDIO_REGS_SHADOW_EN
      v[i*PS +: PS] = mOut[i][PS-1:0];
`else
      v[i*PS +: PS] = mFreq[i][PS-1:0];
`endif
    end
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin mFreq[i] = 0; mOut[i] = 0; end
    mEn = '0; mIrqEn = 0; mPend = 0; mReady = 0; mGpio = 0; mCnt = 0; mRdata = 0;
  endtask

  // One bus/tick cycle of the register bank, applied in terms of the register map rules.
  task automatic modelStep();
    logic acc, wr, oldIrqEn;
    int idx;
    logic [31:0] m, wd, rd, c;
    acc = iomem_valid && (iomem_addr[31:24] == BASE) && !mReady;
    wr  = acc && (iomem_wstrb != 4'h0);
    idx = int'(iomem_addr[7:2]);
    m   = byteMask(iomem_wstrb);
    wd  = iomem_wdata;
    rd  = modelRead(idx);
    oldIrqEn = mIrqEn;
    if (sample_tick) for (int i = 0; i < NCH; i++) mOut[i] = mFreq[i];
    if (wr && idx == NCH + 2) mCnt = sample_tick ? 32'd1 : 32'd0;
    else if (sample_tick) mCnt = mCnt + 1;
    if (sample_tick && oldIrqEn) mPend = 1;
    else if (acc && idx == NCH + 2) mPend = 0;
    if (wr) begin
      if (idx < NCH) mFreq[idx] = ((mFreq[idx] & ~m) | (wd & m)) & PSMASK;
      else if (idx == NCH) begin
        c = (modelRead(NCH) & ~m) | (wd & m);
        mEn = c[NCH-1:0];
        mIrqEn = c[16];
      end else if (idx == NCH + 1) mGpio = (mGpio & ~m) | (wd & m);
    end
    mReady = acc;
    if (acc) mRdata = rd;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) modelReset();
      else modelStep();
    end
  end

  // Every falling edge: all DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("ready",   iomem_ready, mReady);
      checkOutput("rdata",   iomem_rdata, mRdata);
      checkOutput("ch_freq", ch_freq, modelChFreq());
      checkOutput("ch_en",   ch_enable, mEn);
      checkOutput("gpio",    gpio, mGpio);
      checkOutput("irq",     irq, mPend && mIrqEn);
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, input logic t);
    @(negedge clk);
    #1;
    iomem_valid = v; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; sample_tick = t;
  endtask

  task automatic busAccess(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic t);
    applyStimulus(1'b1, a, s, d, t);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    capReady1 = iomem_ready; capRd = iomem_rdata; capIrq = irq;
    capFreq = ch_freq; capEn = ch_enable; capGpio = gpio;
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    capReady2 = iomem_ready;
  endtask

  function automatic logic [31:0] regAddr(input int idx);
    return {BASE, 16'h0, 6'(idx), 2'b00};
  endfunction

  initial begin
    reset = 1'b1;
    iomem_valid = 1'b1; iomem_addr = regAddr(NCH + 1); iomem_wstrb = 4'hF;
    iomem_wdata = 32'hDEAD_BEEF; sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset no ready", iomem_ready, 1'b0);
    checkOutput("reset gpio", gpio, 32'h0);
    checkOutput("reset rdata", iomem_rdata, 32'h0);
    #1 reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    checkOutput("post-reset ready pulse", iomem_ready, 1'b1);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    checkOutput("post-reset ready drop", iomem_ready, 1'b0);
    checkOutput("post-reset gpio", gpio, 32'hDEAD_BEEF);

    busAccess(32'h0400_0004, 4'b0101, 32'h1234_5678, 1'b0);
    checkOutput("bytewr ready", capReady1, 1'b1);
    checkOutput("bytewr single pulse", capReady2, 1'b0);
    busAccess(32'h0400_0004, 4'h0, 32'h0, 1'b0);
    checkOutput("bytewr readback", capRd, 32'h0034_0078);

    busAccess(32'h0400_0000, 4'hF, 32'hFFFF_FFFF, 1'b0);
    busAccess(32'h0400_0000, 4'h0, 32'h0, 1'b0);
    checkOutput("clip readback", capRd, 32'h00FF_FFFF);

    busAccess(32'h0500_0000, 4'h0, 32'h0, 1'b0);
    checkOutput("unselected no ready", capReady1, 1'b0);
    checkOutput("unselected rdata held", capRd, 32'h00FF_FFFF);
    busAccess(regAddr(NCH + 5), 4'h0, 32'h0, 1'b0);
    checkOutput("unmapped ready", capReady1, 1'b1);
    checkOutput("unmapped rdata", capRd, 32'h0);

    busAccess(regAddr(NCH), 4'hF, 32'h0001_0005, 1'b0);
    checkOutput("ctrl enables", capEn, 4'b0101);
    busAccess(regAddr(NCH + 2), 4'hF, 32'h0, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    checkOutput("irq after ticks", irq, 1'b1);
    busAccess(regAddr(NCH + 2), 4'h0, 32'h0, 1'b0);
    checkOutput("tickcnt 3", capRd, 32'd3);
    checkOutput("irq cleared by read", capIrq, 1'b0);
    busAccess(regAddr(NCH + 2), 4'h0, 32'h0, 1'b1);
    checkOutput("tick vs read count", capRd, 32'd3);
    checkOutput("tick wins over read", capIrq, 1'b1);
    busAccess(regAddr(NCH + 2), 4'hF, 32'h0, 1'b1);
    checkOutput("tick wins over clear irq", capIrq, 1'b1);
    busAccess(regAddr(NCH + 2), 4'h0, 32'h0, 1'b0);
    checkOutput("count after clear+tick", capRd, 32'd1);

    busAccess(regAddr(2), 4'hF, 32'h0000_1000, 1'b0);
`ifdef IOMEM_AUDIO_REGS_SHADOW_EN
    checkOutput("ch2 before tick", capFreq[2*PS +: PS], 24'h0);
`else
    checkOutput("ch2 after write", capFreq[2*PS +: PS], 24'h1000);
`endif
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    checkOutput("ch2 after tick", ch_freq[2*PS +: PS], 24'h1000);

    busAccess(regAddr(NCH + 1), 4'b1100, 32'hA5A5_A5A5, 1'b0);
    checkOutput("gpio bytes", capGpio, 32'hA5A5_BEEF);

    for (int n = 0; n < 1500; n++) begin
      logic [7:0] b;
      logic [3:0] s;
      b = ($urandom_range(0, 7) == 0) ? 8'h05 : BASE;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      applyStimulus(1'($urandom_range(0, 2) != 0),
                    {b, 16'($urandom), 6'($urandom_range(0, NCH + 5)), 2'($urandom)},
                    s, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    applyStimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
